// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encoding and default widths.
package mux_scan_pkg;

    localparam int DEF_SEL_WIDTH    = 2;
    localparam int DEF_NUM_INPUTS   = 4;
    localparam int DEF_DWELL_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mux_scan_dwell_counter.sv
// Settle counter: counts enabled cycles and flags the last one (count == DWELL_CYCLES-1),
// wrapping to zero on that cycle so each select gets a fresh dwell window.
module mux_scan_dwell_counter #(
    parameter int DWELL_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign terminal = (count == LAST);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a mux's select lines through every input, samples its output after a settle
// time, and returns the word with a done pulse. Optional parity output: MUX_SCAN_PARITY_EN.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_WIDTH    = DEF_SEL_WIDTH,
    parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mux_out,
    output logic [SEL_WIDTH-1:0]  select_lines,
    output logic [NUM_INPUTS-1:0] captured_lines,
    output logic                  busy,
    output logic                  done
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                  parity
`endif
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

    scan_state_t state, state_next;
    logic [SEL_WIDTH-1:0]  idx;
    logic [NUM_INPUTS-1:0] captured_next;
    logic start_scan, sample_en, last_sample;
    logic dwell_enable, dwell_terminal;

    mux_scan_dwell_counter #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_scan),
        .enable   (dwell_enable),
        .terminal (dwell_terminal)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        start_scan    = 1'b0;
        sample_en     = 1'b0;
        last_sample   = 1'b0;
        dwell_enable  = 1'b0;
        captured_next = captured_lines;
        captured_next[idx] = mux_out;
        case (state)
            IDLE: begin
                if (start) begin
                    start_scan = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                dwell_enable = 1'b1;
                if (dwell_terminal) state_next = SAMPLE;
            end
            SAMPLE: begin
                sample_en = 1'b1;
                if (idx == LAST_IDX) begin
                    last_sample = 1'b1;
                    state_next  = DONE;
                end else begin
                    state_next = SETTLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the capture word is a plain register, not a memory, so it is reset
    // here: a mid-scan reset must discard partial results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            select_lines   <= '0;
            captured_lines <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state <= state_next;
            done  <= last_sample;
            if (start_scan) begin
                idx          <= '0;
                select_lines <= '0;
                busy         <= 1'b1;
            end
            if (sample_en) begin
                captured_lines <= captured_next;
                // select stays on the last input after the final sample
                if (!last_sample) begin
                    idx          <= idx + SEL_WIDTH'(1);
                    select_lines <= select_lines + SEL_WIDTH'(1);
                end
            end
            if (last_sample) busy <= 1'b0;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (last_sample) begin
            parity <= ^captured_next;
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: two sequencers (dwell 1 and dwell 3) each feeding a gate-level 4:1 mux;
// expected words are queued at start and compared at done. Parity checked with MUX_SCAN_PARITY_EN.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start3;
    logic [3:0] in1, in3;
    logic [1:0] sel1, sel3;
    logic [3:0] cap1, cap3;
    logic       busy1, busy3, done1, done3;
    logic       mux1, mux3;
    logic       par1, par3;

    logic       which;
    logic [1:0] o_sel;
    logic [3:0] o_cap;
    logic       o_busy, o_done, o_par;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] sb_exp;

    always #5 clk = ~clk;

    // gate-level 4:1 muxes
    assign mux1 = (in1[0] & ~sel1[1] & ~sel1[0]) | (in1[1] & ~sel1[1] & sel1[0]) |
                  (in1[2] &  sel1[1] & ~sel1[0]) | (in1[3] &  sel1[1] & sel1[0]);
    assign mux3 = (in3[0] & ~sel3[1] & ~sel3[0]) | (in3[1] & ~sel3[1] & sel3[0]) |
                  (in3[2] &  sel3[1] & ~sel3[0]) | (in3[3] &  sel3[1] & sel3[0]);

    mux_scan_sequencer u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .start          (start1),
        .mux_out        (mux1),
        .select_lines   (sel1),
        .captured_lines (cap1),
        .busy           (busy1),
        .done           (done1)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity         (par1)
`endif
    );

    mux_scan_sequencer #(
        .DWELL_CYCLES (3)
    ) u_dut3 (
        .clk            (clk),
        .reset          (reset),
        .start          (start3),
        .mux_out        (mux3),
        .select_lines   (sel3),
        .captured_lines (cap3),
        .busy           (busy3),
        .done           (done3)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity         (par3)
`endif
    );

`ifndef MUX_SCAN_PARITY_EN
    assign par1 = 1'b0;
    assign par3 = 1'b0;
`endif

    assign o_sel  = which ? sel3  : sel1;
    assign o_cap  = which ? cap3  : cap1;
    assign o_busy = which ? busy3 : busy1;
    assign o_done = which ? done3 : done1;
    assign o_par  = which ? par3  : par1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: each done pops the word queued when its scan was launched
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_word", 32'(o_cap), 32'(sb_exp));
`ifdef MUX_SCAN_PARITY_EN
                check("parity", 32'(o_par), 32'(^sb_exp));
`endif
            end
        end
    end

    task automatic drive_start(input logic v);
        if (which) start3 = v;
        else       start1 = v;
    endtask

    // called right after a negedge; launches one scan and follows it to done
    task automatic do_scan(input logic [3:0] lines, input logic slow, input logic extra);
        int dw;
        int k;
        int d0;
        dw    = slow ? 3 : 1;
        which = slow;
        if (slow) in3 = lines;
        else      in1 = lines;
        exp_q.push_back(lines);
        d0 = done_cnt;
        drive_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_start(1'b0);
        k = 0;
        while (o_done !== 1'b1 && k < 200) begin
            check("busy_scan", 32'(o_busy), 32'd1);
            check("sel_step", 32'(o_sel), 32'(k / (dw + 1)));
            if (extra) drive_start((k == 2 || k == 4) ? 1'b1 : 1'b0);
            @(negedge clk);
            k++;
        end
        drive_start(1'b0);
        check("done_latency", 32'(k), 32'(4 * (dw + 1)));
        check("busy_at_done", 32'(o_busy), 32'd0);
        check("sel_at_done", 32'(o_sel), 32'd3);
        @(negedge clk);
        check("done_pulse_width", 32'(o_done), 32'd0);
        check("sel_hold_idle", 32'(o_sel), 32'd3);
        check("cap_hold", 32'(o_cap), 32'(lines));
        check("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;
        int n;
        int d[3];

        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        in1    = 4'b0000;
        in3    = 4'b0000;
        which  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel1",  32'(sel1),  32'd0);
        check("rst_cap1",  32'(cap1),  32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_par1",  32'(par1),  32'd0);
        check("rst_sel3",  32'(sel3),  32'd0);
        check("rst_cap3",  32'(cap3),  32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic scan, then slow dwell, then extra starts mid-scan
        do_scan(4'b1101, 1'b0, 1'b0);
        do_scan(4'b0110, 1'b1, 1'b0);
        do_scan(4'b1011, 1'b0, 1'b1);

        // reset in the middle of a scan
        which = 1'b0;
        in1   = 4'b0100;
        exp_q.push_back(in1);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_sel",  32'(sel1),  32'd0);
        check("midrst_cap",  32'(cap1),  32'd0);
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_done", 32'(done1), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        do_scan(4'b1101, 1'b0, 1'b0);

        // start held high: back-to-back scans one IDLE cycle apart
        which = 1'b0;
        in1   = 4'b1101;
        repeat (3) exp_q.push_back(4'b1101);
        d = '{0, 0, 0};
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        n = 0;
        while (n < 3 && k < 100) begin
            if (done1 === 1'b1) begin
                d[n] = k;
                n++;
            end
            if (n < 3) begin
                @(negedge clk);
                k++;
            end
        end
        start1 = 1'b0;
        check("held_done_count", 32'(n), 32'd3);
        check("held_first_done", 32'(d[0]), 32'd8);
        check("held_period_a", 32'(d[1] - d[0]), 32'd10);
        check("held_period_b", 32'(d[2] - d[1]), 32'd10);
        repeat (3) @(negedge clk);
        check("held_queue_drained", 32'(exp_q.size()), 32'd0);
        check("held_idle_busy", 32'(busy1), 32'd0);

        // odd then even population (parity 1 then 0 when enabled)
        do_scan(4'b1101, 1'b0, 1'b0);
        do_scan(4'b1001, 1'b0, 1'b0);
`ifdef MUX_SCAN_PARITY_EN
        check("parity_hold", 32'(par1), 32'd0);
`endif
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
